match_controller: RTL and testbench



---
 rtl/match_controller.sv | 161 ++++++++++++++++
 tb/tb_match_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Match sequencer for the ball-and-paddle game: runs serve delay, play,
// point pause and game over, owns the scores and the latched mode/bat size.
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | attract screen, mode/bat size track the selectors
// SERVE_WAIT  | ball parked, counting frames before the first serve
// PLAY        | ball live, watching for goals
// POINT_PAUSE | ball parked after a goal, counting frames to next serve
// GAME_OVER   | final scores and winner held until the next start
module match_controller #(
  parameter int WIN_SCORE          = 15,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick_i,
  input  logic       start_i,
  input  logic [1:0] mode_sel_i,
  input  logic       bat_sel_i,
  input  logic       goal_p1_i,
  input  logic       goal_p2_i,
  output logic [1:0] mode_o,
  output logic       bat_size_o,
  output logic [4:0] p1_score_o,
  output logic [4:0] p2_score_o,
  output logic       ball_run_o,
  output logic       ball_reset_o,
  output logic       serve_dir_o,
  output logic       game_over_o,
  output logic       winner_o
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE_WAIT  = 3'd1,
    PLAY        = 3'd2,
    POINT_PAUSE = 3'd3,
    GAME_OVER   = 3'd4
  } state_t;

  localparam logic [4:0] WIN_Q    = 5'(WIN_SCORE);
  localparam logic [7:0] DELAY_Q  = 8'(SERVE_DELAY_FRAMES);
  localparam logic [1:0] PRACTICE = 2'b11;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       start_q;
  logic [1:0] mode_q;
  logic       bat_q;
  logic [4:0] p1_q, p2_q;
  logic       run_q, rst_pulse_q, dir_q, over_q, win_q;

  logic       start_edge_d;
  logic       match_start_d;
  logic [4:0] p1_inc_d, p2_inc_d;

  // Edge detect on start and the next-score values used by the win check.
  always_comb begin
    start_edge_d  = start_i & ~start_q;
    match_start_d = start_edge_d & ((state_q == IDLE) | (state_q == GAME_OVER));
    p1_inc_d      = p1_q + 5'd1;
    p2_inc_d      = p2_q + 5'd1;
  end

  // Match state machine with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      start_q     <= 1'b1;  // a start held through reset must not start a match
      mode_q      <= 2'b00;
      bat_q       <= 1'b0;
      p1_q        <= 5'd0;
      p2_q        <= 5'd0;
      run_q       <= 1'b0;
      rst_pulse_q <= 1'b0;
      dir_q       <= 1'b0;
      over_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      start_q     <= start_i;
      rst_pulse_q <= 1'b0;
      if (match_start_d) begin
        p1_q        <= 5'd0;
        p2_q        <= 5'd0;
        over_q      <= 1'b0;
        mode_q      <= mode_sel_i;
        bat_q       <= bat_sel_i;
        dir_q       <= 1'b1;
        rst_pulse_q <= 1'b1;
        run_q       <= 1'b0;
        cnt_q       <= DELAY_Q;
        state_q     <= SERVE_WAIT;
      end else begin
        case (state_q)
          IDLE: begin
            mode_q <= mode_sel_i;
            bat_q  <= bat_sel_i;
            p1_q   <= 5'd0;
            p2_q   <= 5'd0;
          end
          SERVE_WAIT, POINT_PAUSE: begin
            run_q <= 1'b0;
            if (frame_tick_i) begin
              if (cnt_q == 8'd1) begin
                run_q   <= 1'b1;
                state_q <= PLAY;
              end
              cnt_q <= cnt_q - 8'd1;
            end
          end
          PLAY: begin
            run_q <= 1'b1;
            if (goal_p1_i | goal_p2_i) begin
              run_q       <= 1'b0;
              rst_pulse_q <= 1'b1;
              cnt_q       <= DELAY_Q;
              state_q     <= POINT_PAUSE;
              if (goal_p1_i & ~goal_p2_i) dir_q <= 1'b1;
              if (goal_p2_i & ~goal_p1_i) dir_q <= 1'b0;
              if (mode_q == PRACTICE) begin
                // practice counts every miss, simultaneous pulses included
                if (p2_q != 5'd31) p2_q <= p2_inc_d;
              end else if (goal_p1_i & ~goal_p2_i) begin
                p1_q <= p1_inc_d;
                if (p1_inc_d == WIN_Q) begin
                  state_q <= GAME_OVER;
                  over_q  <= 1'b1;
                  win_q   <= 1'b0;
                end
              end else if (goal_p2_i & ~goal_p1_i) begin
                p2_q <= p2_inc_d;
                if (p2_inc_d == WIN_Q) begin
                  state_q <= GAME_OVER;
                  over_q  <= 1'b1;
                  win_q   <= 1'b1;
                end
              end
            end
          end
          GAME_OVER: begin
            run_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mode_o       = mode_q;
  assign bat_size_o   = bat_q;
  assign p1_score_o   = p1_q;
  assign p2_score_o   = p2_q;
  assign ball_run_o   = run_q;
  assign ball_reset_o = rst_pulse_q;
  assign serve_dir_o  = dir_q;
  assign game_over_o  = over_q;
  assign winner_o     = win_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a short serve delay and low win score.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic       bat_sel = 1'b0;
  logic       goal_p1 = 1'b0;
  logic       goal_p2 = 1'b0;
  logic [1:0] mode;
  logic       bat_size;
  logic [4:0] p1_score, p2_score;
  logic       ball_run, ball_reset, serve_dir, game_over, winner;

  int n_checks = 0;
  int n_fail   = 0;
  logic over_seen;

  match_controller #(.WIN_SCORE(3), .SERVE_DELAY_FRAMES(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .start_i      (start),
    .mode_sel_i   (mode_sel),
    .bat_sel_i    (bat_sel),
    .goal_p1_i    (goal_p1),
    .goal_p2_i    (goal_p2),
    .mode_o       (mode),
    .bat_size_o   (bat_size),
    .p1_score_o   (p1_score),
    .p2_score_o   (p2_score),
    .ball_run_o   (ball_run),
    .ball_reset_o (ball_reset),
    .serve_dir_o  (serve_dir),
    .game_over_o  (game_over),
    .winner_o     (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  // three frames: ball goes live on the edge that samples the third tick
  task automatic pause();
    frame(); frame(); frame();
  endtask

  task automatic goal(input logic g1, input logic g2);
    goal_p1 = g1;
    goal_p2 = g2;
    step();
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_bat"}, bat_size, 0);
    check({tag, "_p1"}, p1_score, 0);
    check({tag, "_p2"}, p2_score, 0);
    check({tag, "_run"}, ball_run, 0);
    check({tag, "_breset"}, ball_reset, 0);
    check({tag, "_dir"}, serve_dir, 0);
    check({tag, "_over"}, game_over, 0);
    check({tag, "_winner"}, winner, 0);
  endtask

  initial begin
    // reset
    step(); step();
    rst = 1'b0;
    step();
    check_reset_outputs("rst0");

    // 1: start match in football, small bat; tick on start edge is not counted
    mode_sel = 2'b01; bat_sel = 1'b1;
    step();
    check("idle_follow_mode", mode, 1);
    check("idle_follow_bat", bat_size, 1);
    start = 1'b1; frame_tick = 1'b1;
    step();
    start = 1'b0; frame_tick = 1'b0;
    check("t1_breset_pulse", ball_reset, 1);
    check("t1_dir", serve_dir, 1);
    check("t1_run_wait", ball_run, 0);
    step();
    check("t1_breset_end", ball_reset, 0);
    mode_sel = 2'b00; bat_sel = 1'b0;
    frame(); frame();
    check("t1_run_after2", ball_run, 0);
    frame();
    check("t1_run_after3", ball_run, 1);
    check("t1_mode_frozen", mode, 1);
    check("t1_bat_frozen", bat_size, 1);

    // 2: P2 scores, goals during the pause are ignored
    goal(1'b0, 1'b1);
    check("t2_p2", p2_score, 1);
    check("t2_dir", serve_dir, 0);
    check("t2_run", ball_run, 0);
    check("t2_breset", ball_reset, 1);
    step();
    check("t2_breset_end", ball_reset, 0);
    goal(1'b1, 1'b0);
    check("t2_pause_goal_p1", p1_score, 0);
    frame(); frame();
    goal(1'b0, 1'b1);
    check("t2_pause_goal_p2", p2_score, 1);
    check("t2_run_paused", ball_run, 0);
    frame();
    check("t2_run_back", ball_run, 1);

    // 3: P1 wins at 3
    goal(1'b1, 1'b0); pause();
    goal(1'b1, 1'b0); pause();
    check("t3_p1_2", p1_score, 2);
    check("t3_not_over", game_over, 0);
    goal(1'b1, 1'b0);
    check("t3_p1_3", p1_score, 3);
    check("t3_over", game_over, 1);
    check("t3_winner", winner, 0);
    check("t3_run", ball_run, 0);
    check("t3_breset", ball_reset, 1);
    step(); step();
    goal(1'b0, 1'b1);
    check("t3_ignored_p2", p2_score, 1);
    check("t3_still_over", game_over, 1);
    pause();
    check("t3_no_serve", ball_run, 0);
    mode_sel = 2'b01; bat_sel = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_restart_p1", p1_score, 0);
    check("t3_restart_p2", p2_score, 0);
    check("t3_restart_over", game_over, 0);
    check("t3_restart_breset", ball_reset, 1);
    check("t3_restart_bat", bat_size, 0);
    pause();
    check("t3_serve_wait_done", ball_run, 1);

    // 4: simultaneous goals at 2/2 replay the point
    goal(1'b1, 1'b0); pause();
    goal(1'b0, 1'b1); pause();
    goal(1'b1, 1'b0); pause();
    goal(1'b0, 1'b1); pause();
    check("t4_pre_p1", p1_score, 2);
    check("t4_pre_p2", p2_score, 2);
    goal(1'b1, 1'b1);
    check("t4_p1", p1_score, 2);
    check("t4_p2", p2_score, 2);
    check("t4_dir", serve_dir, 0);
    check("t4_breset", ball_reset, 1);
    check("t4_run", ball_run, 0);
    check("t4_over", game_over, 0);
    frame(); frame();
    check("t4_paused", ball_run, 0);
    frame();
    check("t4_resume", ball_run, 1);

    // 6: mode_sel and start ignored in PLAY, then async reset mid-PLAY
    mode_sel = 2'b10;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t6_mode_held", mode, 1);
    check("t6_still_play", ball_run, 1);
    check("t6_no_breset", ball_reset, 0);
    check("t6_scores_kept", p1_score, 2);
    start = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    step();
    #3;
    rst = 1'b0;
    step(); step(); step();
    check("t6_held_start_dir", serve_dir, 0);
    check("t6_held_start_breset", ball_reset, 0);
    check("t6_idle_mode", mode, 2);
    pause();
    check("t6_held_start_run", ball_run, 0);
    start = 1'b0;

    // 5: practice mode saturates the miss count
    mode_sel = 2'b11;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    pause();
    over_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 4) goal(1'b1, 1'b1);
      else if (i % 2 == 0) goal(1'b1, 1'b0);
      else goal(1'b0, 1'b1);
      over_seen = over_seen | game_over;
      if (i == 29) check("t5_p2_at30", p2_score, 30);
      if (i == 30) check("t5_p2_at31", p2_score, 31);
      pause();
      over_seen = over_seen | game_over;
    end
    check("t5_p2_sat", p2_score, 31);
    check("t5_p1_zero", p1_score, 0);
    check("t5_never_over", over_seen, 0);
    check("t5_mode", mode, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
